// File: rtl/bist_signature_checker.sv
// bist_signature_checker
// Back end of a BIST session. While the controller reports "running", a Galois LFSR
// drives test patterns into the circuit under test. The CUT responses are folded into a
// MISR signature. When the controller pulses bist_end, the signature is compared against
// a golden value, and the pass/fail verdict is held until the next session starts.
module bist_signature_checker #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = 8'hB8,
  parameter logic [WIDTH-1:0] LFSR_SEED  = 8'h01,
  parameter logic [WIDTH-1:0] MISR_SEED  = 8'h00,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = 8'h00,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             running,
  input  logic             bist_end,
  input  logic [WIDTH-1:0] cut_resp,
  output logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pattern_count,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] pattern_q, signature_q;
  logic [CNT_W-1:0] count_q;
  logic             done_q, pass_q, fail_q;

  // Per-cycle control decoded from the FSM
  logic absorb;
  logic load_seeds;
  logic set_verdict;
  logic clr_verdict;
  logic sig_match;

  // One Galois shift. The LFSR and the MISR share the same feedback polynomial.
  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction

  // The count holds at all-ones so that a very long session cannot wrap to a small value
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign sig_match = (signature_q == GOLDEN_SIG);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. In RUN, bist_end takes priority over running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (running) state_d = S_RUN;
      S_RUN: begin
        if (bist_end)      state_d = S_EVAL;
        else if (!running) state_d = S_IDLE;
      end
      S_EVAL: state_d = S_DONE;
      S_DONE: if (running) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/control decode. The entry edge into RUN never absorbs, so the first absorbed
  // pattern is the seed.
  always_comb begin
    absorb      = 1'b0;
    load_seeds  = 1'b0;
    set_verdict = 1'b0;
    clr_verdict = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (!bist_end) begin
          if (running) absorb     = 1'b1;
          else         load_seeds = 1'b1;  // aborted session: back to seeds, no verdict
        end
      end
      S_EVAL: set_verdict = 1'b1;
      S_DONE: begin
        if (running) begin
          load_seeds  = 1'b1;
          clr_verdict = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pattern generator, signature compactor, and absorbed-pattern counter
  always_ff @(posedge clk) begin
    if (reset || load_seeds) begin
      pattern_q   <= LFSR_SEED;
      signature_q <= MISR_SEED;
      count_q     <= '0;
    end else if (absorb) begin
      pattern_q   <= galois_step(pattern_q);
      signature_q <= galois_step(signature_q) ^ cut_resp;
      count_q     <= sat_inc(count_q);
    end
  end

  // Verdict latch. It is written only once, from EVAL, and is cleared when a new run starts.
  always_ff @(posedge clk) begin
    if (reset || clr_verdict) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (set_verdict) begin
      done_q <= 1'b1;
      pass_q <= sig_match;
      fail_q <= ~sig_match;
    end
  end

  assign pattern       = pattern_q;
  assign signature     = signature_q;
  assign pattern_count = count_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Testbench for bist_signature_checker. A session-level reference model is compared
// against the DUT every cycle. Directed scenarios use literal expectations, and a
// randomized phase follows them.
module tb_bist_signature_checker;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 16;
  localparam logic [7:0] POLY  = 8'hB8;
  localparam logic [7:0] LSEED = 8'h01;
  localparam logic [7:0] MSEED = 8'h00;
  localparam logic [7:0] GOLD  = 8'h00;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             running = 1'b0;
  logic             bist_end = 1'b0;
  logic [WIDTH-1:0] cut_resp = '0;
  logic [WIDTH-1:0] pattern, signature;
  logic [CNT_W-1:0] pattern_count;
  logic             done, pass, fail;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  bist_signature_checker #(
    .WIDTH(WIDTH), .POLY(POLY), .LFSR_SEED(LSEED), .MISR_SEED(MSEED),
    .GOLDEN_SIG(GOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .running(running), .bist_end(bist_end),
    .cut_resp(cut_resp), .pattern(pattern), .signature(signature),
    .pattern_count(pattern_count), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  // Reference model. session: 0 = not started, 1 = collecting, 2 = verdict due, 3 = verdict held
  int         m_session = 0;
  logic [7:0] m_pat = LSEED;
  logic [7:0] m_sig = MSEED;
  int         m_cnt = 0;
  bit         m_done = 0, m_pass = 0, m_fail = 0;

  function automatic logic [7:0] step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 8'h00);
  endfunction

  task automatic fresh_run();
    m_pat = LSEED; m_sig = MSEED; m_cnt = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_session = 0; fresh_run();
      m_done = 0; m_pass = 0; m_fail = 0;
    end else if (m_session == 0) begin
      if (running) m_session = 1;
    end else if (m_session == 1) begin
      if (bist_end) m_session = 2;
      else if (running) begin
        m_sig = step(m_sig) ^ cut_resp;
        m_pat = step(m_pat);
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_session = 0; fresh_run();
      end
    end else if (m_session == 2) begin
      m_done = 1; m_pass = (m_sig == GOLD); m_fail = (m_sig != GOLD);
      m_session = 3;
    end else begin
      if (running) begin
        m_session = 1; fresh_run();
        m_done = 0; m_pass = 0; m_fail = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("pattern", 32'(pattern), 32'(m_pat));
      check("signature", 32'(signature), 32'(m_sig));
      check("pattern_count", 32'(pattern_count), 32'(m_cnt));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("fail", 32'(fail), 32'(m_fail));
      check("pass_fail_excl", 32'(pass & fail), 32'd0);
      check("verdict_gated", 32'((pass | fail) & ~done), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The DUT is now in RUN, with bist_end low. Absorb n patterns using a zero response.
  task automatic absorb_zero(input int n);
    for (int i = 0; i < n; i++) begin
      cut_resp = 8'h00;
      tick();
    end
  endtask

  initial begin
    // 1. Reset, then stay idle
    reset = 1'b1; running = 1'b0; bist_end = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_pattern", 32'(pattern), 32'h01);
    check("idle_signature", 32'(signature), 32'h00);
    check("idle_done", 32'({done, pass, fail}), 32'h0);

    // 2. Five absorbs with a zero response
    running = 1'b1;
    tick();                              // entry into the session: no absorb
    check("entry_pattern", 32'(pattern), 32'h01);
    check("entry_count", 32'(pattern_count), 32'd0);
    absorb_zero(1); check("pat1", 32'(pattern), 32'hB8);
    absorb_zero(1); check("pat2", 32'(pattern), 32'h5C);
    absorb_zero(1); check("pat3", 32'(pattern), 32'h2E);
    absorb_zero(1); check("pat4", 32'(pattern), 32'h17);
    absorb_zero(1); check("pat5", 32'(pattern), 32'hB3);
    check("sig_zero", 32'(signature), 32'h00);
    // 4. Assert running and bist_end together: no absorb on that edge
    bist_end = 1'b1;
    tick();
    bist_end = 1'b0; running = 1'b0;
    check("end_no_absorb_cnt", 32'(pattern_count), 32'd5);
    check("end_no_absorb_pat", 32'(pattern), 32'hB3);
    check("end_done_not_yet", 32'(done), 32'd0);
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_count", 32'(pattern_count), 32'd5);
    // 6. Pulse bist_end while a verdict is held: no effect
    bist_end = 1'b1; tick(); bist_end = 1'b0; tick();
    check("done_ignores_end", 32'({done, pass, fail}), 32'b110);

    // 3. Loopback of two patterns
    running = 1'b1;
    tick();
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_pattern", 32'(pattern), 32'h01);
    cut_resp = m_pat; tick();
    check("loop_sig1", 32'(signature), 32'h01);
    cut_resp = m_pat; tick();
    check("loop_sig2", 32'(signature), 32'h00);
    bist_end = 1'b1; tick(); bist_end = 1'b0; running = 1'b0; tick();
    check("loop_pass", 32'({done, pass, fail}), 32'b110);

    // Loopback again, with one response bit flipped
    running = 1'b1; tick();
    cut_resp = 8'h02; tick();
    check("flip_sig1", 32'(signature), 32'h02);
    cut_resp = m_pat; tick();
    check("flip_sig2", 32'(signature), 32'hB9);
    bist_end = 1'b1; tick(); bist_end = 1'b0; running = 1'b0; tick();
    check("flip_fail", 32'({done, pass, fail}), 32'b101);

    // 5. Reset in the middle of a run
    running = 1'b1; tick();
    absorb_zero(3);
    check("mid_count", 32'(pattern_count), 32'd3);
    reset = 1'b1; tick(); reset = 1'b0; running = 1'b0;
    check("rst_pattern", 32'(pattern), 32'h01);
    check("rst_sig_cnt", 32'({signature, pattern_count}), 32'h0);
    check("rst_verdict", 32'({done, pass, fail}), 32'h0);
    // Abort by dropping running without bist_end
    running = 1'b1; tick();
    absorb_zero(2);
    running = 1'b0; tick();
    check("abort_count", 32'(pattern_count), 32'd0);
    check("abort_pattern", 32'(pattern), 32'h01);
    check("abort_done", 32'(done), 32'd0);
    // bist_end while idle: no effect
    bist_end = 1'b1; tick(); bist_end = 1'b0; tick(); tick();
    check("idle_ignores_end", 32'(done), 32'd0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      running  = ($urandom_range(0, 9) != 0);
      bist_end = ($urandom_range(0, 19) == 0);
      cut_resp = ($urandom_range(0, 3) == 0) ? m_pat : 8'($urandom);
      tick();
    end
    reset = 1'b0; running = 1'b0; bist_end = 1'b0;
    tick(); tick();
    chk_en = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
